// File: rtl/collision_detect_pkg.sv
// Shared types and constants for the frog collision detector.
//   lane_type_e : what kind of terrain a lane is (SAFE, ROAD, RIVER)
//   state_e     : evaluation FSM states
//   LANE_TABLE  : fixed lane-index -> lane-type map for the playfield
package collision_detect_pkg;

  typedef enum logic [1:0] {
    SAFE  = 2'd0,
    ROAD  = 2'd1,
    RIVER = 2'd2
  } lane_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int N_LANES = 16;

  // Playfield layout, lane 0 at the top (goal bank).
  localparam lane_type_e LANE_TABLE [N_LANES] = '{
    SAFE,                               // 0      goal bank
    ROAD, ROAD, ROAD, ROAD, ROAD,       // 1..5   traffic
    SAFE,                               // 6      median
    RIVER, RIVER, RIVER, RIVER, RIVER,  // 7..11  river
    SAFE,                               // 12     river bank
    ROAD, ROAD,                         // 13..14 traffic
    SAFE                                // 15     start
  };

  function automatic lane_type_e lane_type_of(input logic [3:0] row);
    return LANE_TABLE[row];
  endfunction

endpackage

// File: rtl/collision_detect_if.sv
// Game-side bus of the collision detector.
//   frame_start, frog_row, frog_col : frame request from the game engine
//   lane_sel / lane_pixels          : lane pixel buffer read port (1-cycle latency)
//   hit, win, overrun               : status back to the game
// master = game/buffer side, slave = collision_detect.
interface collision_detect_if;
  logic        frame_start;
  logic [3:0]  frog_row;
  logic [3:0]  frog_col;
  logic [3:0]  lane_sel;
  logic [15:0] lane_pixels;
  logic        hit;
  logic        win;
  logic        overrun;

  modport master (
    output frame_start, frog_row, frog_col, lane_pixels,
    input  lane_sel, hit, win, overrun
  );

  modport slave (
    input  frame_start, frog_row, frog_col, lane_pixels,
    output lane_sel, hit, win, overrun
  );
endinterface

// File: rtl/collision_detect_lane_hazard.sv
// Combinational hazard test for one frog position.
//   lane_type : terrain of the frog's lane
//   pixels    : lane pixels, bit c = column c
//   col       : frog column (direct bit select, no bounds logic)
//   hazard    : 1 when the frog is in danger
module lane_hazard
  import collision_detect_pkg::*;
(
  input  lane_type_e  lane_type,
  input  logic [15:0] pixels,
  input  logic [3:0]  col,
  output logic        hazard
);

  always_comb begin
    hazard = 1'b0;
    case (lane_type)
      ROAD:    hazard = pixels[col];   // car under the frog
      RIVER:   hazard = ~pixels[col];  // no log under the frog
      default: hazard = 1'b0;
    endcase
  end

endmodule

// File: rtl/collision_detect.sv
// Frog collision detector. Each frame_start captures the frog position,
// reads its lane from the pixel buffer and decides hazard / win with a
// fixed 3-cycle latency. N_CONFIRM consecutive hazardous frames raise a
// sticky hit; a safe arrival on GOAL_ROW pulses win. Either ends the game
// (DONE) until reset.
//   clk, reset : clock, synchronous active-high reset
//   bus        : collision_detect_if.slave (see interface)
module collision_detect
  import collision_detect_pkg::*;
#(
  parameter int N_CONFIRM = 2,
  parameter int GOAL_ROW  = 0
) (
  input logic              clk,
  input logic              reset,
  collision_detect_if.slave bus
);

  localparam logic [2:0] CONFIRM = 3'(N_CONFIRM);
  localparam logic [3:0] GOAL    = 4'(GOAL_ROW);

  state_e      state_q, state_d;
  logic [3:0]  row_q, row_d;
  logic [3:0]  col_q, col_d;
  logic [3:0]  lane_sel_q, lane_sel_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        hit_q, hit_d;
  logic        win_q, win_d;
  logic        ovr_q, ovr_d;
  logic        hazard;

  lane_hazard u_hazard (
    .lane_type (lane_type_of(row_q)),
    .pixels    (bus.lane_pixels),
    .col       (col_q),
    .hazard    (hazard)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    lane_sel_d = lane_sel_q;
    cnt_d      = cnt_q;
    hit_d      = hit_q;
    win_d      = 1'b0;
    ovr_d      = ovr_q;
    case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          row_d      = bus.frog_row;
          col_d      = bus.frog_col;
          lane_sel_d = bus.frog_row;
          state_d    = READ;
        end
      end
      // Pixel buffer latency; a new frame here is dropped.
      READ: begin
        if (bus.frame_start) ovr_d = 1'b1;
        state_d = EVAL;
      end
      EVAL: begin
        if (bus.frame_start) ovr_d = 1'b1;
        state_d = IDLE;
        if (hazard) begin
          // Hazard wins over goal: only the counter moves.
          cnt_d = (cnt_q >= CONFIRM) ? CONFIRM : cnt_q + 3'd1;
          if (cnt_d == CONFIRM) begin
            hit_d   = 1'b1;
            state_d = DONE;
          end
        end else begin
          cnt_d = 3'd0;
          if (row_q == GOAL) begin
            win_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: ; // absorbing; frame_start ignored
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      lane_sel_q <= '0;
      cnt_q      <= '0;
      hit_q      <= 1'b0;
      win_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      lane_sel_q <= lane_sel_d;
      cnt_q      <= cnt_d;
      hit_q      <= hit_d;
      win_q      <= win_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.lane_sel = lane_sel_q;
  assign bus.hit      = hit_q;
  assign bus.win      = win_q;
  assign bus.overrun  = ovr_q;

endmodule
